// File: rtl/conv_window_gen.sv
// Raster pixel stream to 4x4 windows, stride 2, for the 3x3 conv MAC's 2x2 output tile.
// Optional `CONV_WINDOW_LAST_EN adds oLast, which flags the final window of each frame.
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    output logic             rdy_o,
    input  logic [DW-1:0]    iPix,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic [16*DW-1:0] oWin,
`ifdef CONV_WINDOW_LAST_EN
    output logic             oLast,
`endif
    output logic             oFrameDone
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             vld_q, vld_d;
    logic [16*DW-1:0] win_q, win_d;
    logic             done_q, done_d;
    logic [16*DW-1:0] win_new;
    logic             acc, emit, frame_end;

    // Line storage is a ring of four rows indexed by row[1:0]; the current row
    // overwrites the slot of row r-4, which no future window needs.
    logic [DW-1:0] lb_q [4][IMG_W];
    // Per-row 4-deep column shift registers; index 0 holds column c-3.
    logic [DW-1:0] sr_q [4][4];
    logic [DW-1:0] sr_d [4][4];

    assign rdy_o      = !vld_q || rdy_i;
    assign vld_o      = vld_q;
    assign oWin       = win_q;
    assign oFrameDone = done_q;

    always_comb begin
        acc       = vld_i && rdy_o;
        frame_end = acc && (col_q == COL_LAST) && (row_q == ROW_LAST);
        emit      = acc && (row_q >= RW'(3)) && (col_q >= CW'(3)) && row_q[0] && col_q[0];

        sr_d = sr_q;
        if (acc) begin
            for (int rr = 0; rr < 4; rr++) begin
                for (int j = 0; j < 3; j++) begin
                    sr_d[rr][j] = sr_q[rr][j+1];
                end
            end
            for (int rr = 0; rr < 3; rr++) begin
                sr_d[rr][3] = lb_q[row_q[1:0] + 2'(rr + 1)][col_q];
            end
            sr_d[3][3] = iPix;
        end

        win_new = '0;
        for (int k = 0; k < 16; k++) begin
            win_new[k*DW +: DW] = sr_d[k/4][k%4];
        end

        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A fresh window takes priority over retiring the one being handed off.
        vld_d = vld_q;
        win_d = win_q;
        if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
        if (emit) begin
            vld_d = 1'b1;
            win_d = win_new;
        end
        done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            vld_q  <= 1'b0;
            win_q  <= '0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            vld_q  <= vld_d;
            win_q  <= win_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
        if (acc) begin
            lb_q[row_q[1:0]][col_q] <= iPix;
        end
    end

`ifdef CONV_WINDOW_LAST_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (vld_q && rdy_i) begin
            last_d = 1'b0;
        end
        if (emit) begin
            last_d = frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign oLast = last_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a 4x4 instance and a default 16x16 instance.
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic vi4, ri4, ro4, vo4, fd4;
    logic vi16, ri16, ro16, vo16, fd16;
    logic [7:0] px4, px16;
    logic [127:0] win4, win16;
    logic last4, last16;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .DW(8)) u4 (
        .clk(clk), .rst(rst), .vld_i(vi4), .rdy_o(ro4), .iPix(px4),
        .vld_o(vo4), .rdy_i(ri4), .oWin(win4),
`ifdef CONV_WINDOW_LAST_EN
        .oLast(last4),
`endif
        .oFrameDone(fd4)
    );

    conv_window_gen #(.IMG_W(16), .IMG_H(16), .DW(8)) u16 (
        .clk(clk), .rst(rst), .vld_i(vi16), .rdy_o(ro16), .iPix(px16),
        .vld_o(vo16), .rdy_i(ri16), .oWin(win16),
`ifdef CONV_WINDOW_LAST_EN
        .oLast(last16),
`endif
        .oFrameDone(fd16)
    );

`ifndef CONV_WINDOW_LAST_EN
    assign last4  = 1'b0;
    assign last16 = 1'b0;
`endif

    typedef struct packed {
        logic [127:0] w;
        logic         l;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];
    exp_t e4, e16;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rmode = 0;
    int fd_cnt4 = 0;
    int fd_cnt16 = 0;
    int pop16 = 0;
    int pop_snap;
    logic [127:0] first16, last_win16;
    logic [7:0] img[2][16][16];
    int rr[2];
    int cc[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic rdy_pat();
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return ((cyc / 3) % 2) == 0;
        return 1'b0;
    endfunction

    task automatic step(input int id, input logic v, input logic [7:0] p, output logic acc);
        if (id == 0) begin
            vi4 = v; px4 = p; ri4 = rdy_pat(); ri16 = 1'b1;
        end else begin
            vi16 = v; px16 = p; ri16 = rdy_pat(); ri4 = 1'b1;
        end
        @(negedge clk);
        acc = v && ((id == 0) ? ro4 : ro16);
        @(posedge clk);
        #1;
        vi4 = 1'b0;
        vi16 = 1'b0;
    endtask

    task automatic model(input int id, input logic [7:0] p);
        int w;
        exp_t e;
        w = (id == 0) ? 4 : 16;
        img[id][rr[id]][cc[id]] = p;
        if (rr[id] >= 3 && cc[id] >= 3 && rr[id] % 2 == 1 && cc[id] % 2 == 1) begin
            for (int k = 0; k < 16; k++) begin
                e.w[k*8 +: 8] = img[id][rr[id] - 3 + k / 4][cc[id] - 3 + k % 4];
            end
            e.l = (rr[id] == w - 1) && (cc[id] == w - 1);
            if (id == 0) q4.push_back(e);
            else q16.push_back(e);
        end
        if (cc[id] == w - 1) begin
            cc[id] = 0;
            rr[id] = (rr[id] == w - 1) ? 0 : rr[id] + 1;
        end else begin
            cc[id]++;
        end
    endtask

    task automatic send(input int id, input logic [7:0] p);
        logic a;
        int tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 200) begin
            step(id, 1'b1, p, a);
            tries++;
        end
        if (!a) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end else begin
            model(id, p);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (vo4 && ri4) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL win4_unexpected actual=%h required=none", win4);
                end else begin
                    e4 = q4.pop_front();
                    chk("win4", win4, e4.w);
`ifdef CONV_WINDOW_LAST_EN
                    chk("last4", 128'(last4), 128'(e4.l));
`endif
                end
            end
            if (vo4 && !ri4) chk("rdy4_stall", 128'(ro4), 128'(0));
            if (fd4) fd_cnt4++;

            if (vo16 && ri16) begin
                if (q16.size() == 0) begin
                    total++; bad++;
                    $display("FAIL win16_unexpected actual=%h required=none", win16);
                end else begin
                    e16 = q16.pop_front();
                    chk("win16", win16, e16.w);
`ifdef CONV_WINDOW_LAST_EN
                    chk("last16", 128'(last16), 128'(e16.l));
`endif
                    if (pop16 == 0) first16 = win16;
                    if (pop16 == 48) last_win16 = win16;
                    pop16++;
                end
            end
            if (vo16 && !ri16) chk("rdy16_stall", 128'(ro16), 128'(0));
            if (fd16) fd_cnt16++;
        end
    end

    initial begin
        logic a;
        logic [127:0] h;
        rst = 1'b1;
        vi4 = 1'b0; px4 = '0; ri4 = 1'b1;
        vi16 = 1'b0; px16 = '0; ri16 = 1'b1;
        rr[0] = 0; cc[0] = 0; rr[1] = 0; cc[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_vld16", 128'(vo16), 128'(0));
        chk("rst_win16", win16, 128'(0));
        chk("rst_fd16", 128'(fd16), 128'(0));
        chk("rst_rdy16", 128'(ro16), 128'(1));
        chk("rst_vld4", 128'(vo4), 128'(0));

        // 4x4 frame of 1..16, then 17..32 back to back
        rmode = 0;
        for (int p = 1; p <= 16; p++) send(0, 8'(p));
        for (int k = 0; k < 16; k++) h[k*8 +: 8] = 8'(k + 1);
        chk("win4_f1_direct", win4, h);
        chk("vld4_latency", 128'(vo4), 128'(1));
        chk("fd4_pulse_f1", 128'(fd4), 128'(1));
        for (int p = 17; p <= 32; p++) send(0, 8'(p));
        for (int k = 0; k < 16; k++) h[k*8 +: 8] = 8'(k + 17);
        chk("win4_f2_direct", win4, h);
        chk("fd4_pulse_f2", 128'(fd4), 128'(1));
        repeat (3) step(0, 1'b0, 8'h00, a);
        chk("fd4_count", 128'(fd_cnt4), 128'(2));
        chk("q4_empty", 128'(q4.size()), 128'(0));

        // 16x16 frame A, ready always high
        rmode = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) send(1, 8'(r * 16 + c));
        repeat (2) step(1, 1'b0, 8'h00, a);
        chk("popA_count", 128'(pop16), 128'(49));
        chk("first_b0", 128'(first16[7:0]), 128'(8'h00));
        chk("first_b15", 128'(first16[127:120]), 128'(8'h33));
        chk("last_b0", 128'(last_win16[7:0]), 128'(8'hCC));
        chk("last_b15", 128'(last_win16[127:120]), 128'(8'hFF));

        // frame B, ready toggling every 3 cycles
        rmode = 1;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) send(1, 8'(r * 16 + c));
        repeat (8) step(1, 1'b0, 8'h00, a);
        chk("popB_count", 128'(pop16), 128'(98));

        // aborted frame: stop at row 5 with the (5,5) window held, then reset
        rmode = 0;
        for (int i = 0; i < 5 * 16 + 6; i++) send(1, ~8'(i));
        rmode = 2;
        repeat (2) step(1, 1'b0, 8'h00, a);
        chk("abort_held_q", 128'(q16.size()), 128'(1));
        chk("abort_held_vld", 128'(vo16), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_rst_vld", 128'(vo16), 128'(0));
        chk("abort_rst_win", win16, 128'(0));
        chk("abort_rst_rdy", 128'(ro16), 128'(1));
        q16.delete();
        rr[1] = 0;
        cc[1] = 0;

        // frame C after reset
        rmode = 0;
        pop_snap = pop16;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) send(1, 8'(r * 16 + c) ^ 8'hA5);
        repeat (4) step(1, 1'b0, 8'h00, a);
        chk("popC_count", 128'(pop16 - pop_snap), 128'(49));
        chk("q16_empty", 128'(q16.size()), 128'(0));
        chk("fd16_count", 128'(fd_cnt16), 128'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
